// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared CPU package: datapath widths, fetch FSM state encoding, the default
// halt opcode and the legal program-memory latency range.
package instr_fetch_ctrl_pkg;

  localparam int unsigned reg_width  = 16;
  localparam int unsigned addr_width = 8;

  localparam logic [15:0] HALT_OPCODE_DEFAULT = 16'h0000;

  // Legal ram_q latency bounds in clk cycles; the latency counter is sized
  // to hold RAM_LATENCY_MAX-1.
  localparam int unsigned RAM_LATENCY_MIN = 1;
  localparam int unsigned RAM_LATENCY_MAX = 7;
  localparam int unsigned LAT_CNT_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EXEC,
    ADV,
    HALT,
    EXT
  } fetch_state_t;

endpackage

// File: rtl/genral_purpose_reg.sv
// General purpose register with load enable and asynchronous active-high reset.
// Ports: clk, reset, en (load strobe), d (next value), q (held value).
module genral_purpose_reg #(
  parameter int unsigned D_width = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [D_width-1:0] d,
  output logic [D_width-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: fetches instruction words from program memory
// (or takes them from an external source) and hands them to the control
// circuit, advancing the program counter once each instruction is done.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   mode_sel              - 1 = external instruction mode, 0 = memory fetch
//   external_INSTRUCTION  - externally supplied instruction word
//   ram_q                 - program memory read data
//   done                  - control circuit finished the current instruction
//   cc_wren               - control circuit requests the bus for a RAM write
//   read_enable           - gates the PC onto the address bus (combinational)
//   pc_advance            - one-cycle PC increment pulse
//   INSTRUCTION           - registered instruction word
//   instr_valid           - INSTRUCTION awaits execution
//   halted                - a halt opcode has been fetched
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned         D_WIDTH     = 16,
  parameter int unsigned         RAM_LATENCY = 2,
  parameter logic [D_WIDTH-1:0]  HALT_OPCODE = D_WIDTH'(HALT_OPCODE_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_sel,
  input  logic [D_WIDTH-1:0] external_INSTRUCTION,
  input  logic [D_WIDTH-1:0] ram_q,
  input  logic               done,
  input  logic               cc_wren,
  output logic               read_enable,
  output logic               pc_advance,
  output logic [D_WIDTH-1:0] INSTRUCTION,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t         state, state_next;
  logic [LAT_CNT_W-1:0] cnt, cnt_next;
  logic                 started;
  logic                 abort;
  logic                 instr_en;
  logic [D_WIDTH-1:0]   instr_d;

  // Every non-IDLE state implies a mode: EXT was entered with mode_sel=1,
  // all memory-fetch states with mode_sel=0, so no copy of mode is stored.
  assign abort = (state != IDLE) && ((state == EXT) ? !mode_sel : mode_sel);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        // 'started' holds IDLE for the first edge after reset release.
        if (started) state_next = mode_sel ? EXT : FETCH;
      end
      FETCH: begin
        if (cc_wren) begin
          cnt_next = '0;
        end else if (cnt == LAT_CNT_W'(RAM_LATENCY - 1)) begin
          cnt_next   = '0;
          state_next = LOAD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOAD:    state_next = (ram_q == HALT_OPCODE) ? HALT : EXEC;
      EXEC:    if (done) state_next = ADV;
      ADV:     state_next = FETCH;
      HALT:    state_next = HALT;
      EXT:     state_next = EXT;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      started     <= 1'b0;
      instr_valid <= 1'b0;
      pc_advance  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      started     <= 1'b1;
      instr_valid <= (state_next == EXEC) || (state_next == EXT);
      pc_advance  <= (state_next == ADV);
      halted      <= (state_next == HALT);
    end
  end

  assign read_enable = (state == FETCH) && !cc_wren;

  // Loading on entry to EXT (not only while in it) makes INSTRUCTION valid
  // in the same cycle instr_valid rises; aborts leave the register untouched.
  assign instr_en = ((state == LOAD) && !abort) || (state_next == EXT);
  assign instr_d  = (state == LOAD) ? ram_q : external_INSTRUCTION;

  genral_purpose_reg #(
    .D_width(D_WIDTH)
  ) u_instr_reg (
    .clk  (clk),
    .reset(reset),
    .en   (instr_en),
    .d    (instr_d),
    .q    (INSTRUCTION)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_sel = 1'b0;
  logic [15:0] external_INSTRUCTION = '0;
  logic [15:0] ram_q = '0;
  logic        done = 1'b0;
  logic        cc_wren = 1'b0;
  logic        read_enable;
  logic        pc_advance;
  logic [15:0] INSTRUCTION;
  logic        instr_valid;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;
  logic [15:0] ext_vals [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

  instr_fetch_ctrl #(
    .D_WIDTH(16),
    .RAM_LATENCY(2),
    .HALT_OPCODE(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_sel(mode_sel),
    .external_INSTRUCTION(external_INSTRUCTION),
    .ram_q(ram_q),
    .done(done),
    .cc_wren(cc_wren),
    .read_enable(read_enable),
    .pc_advance(pc_advance),
    .INSTRUCTION(INSTRUCTION),
    .instr_valid(instr_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    done = 1'b0;
    cc_wren = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Advances until instr_valid is seen, bounded; returns edges consumed.
  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    mode_sel = 1'b0;
    reset = 1'b1;
    #2;
    n_checks++; if ({read_enable, pc_advance, instr_valid, halted} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {read_enable, pc_advance, instr_valid, halted}); end
    n_checks++; if (INSTRUCTION !== 16'h0000) begin n_errors++; $display("FAIL reset_instr: got %h expected 0000", INSTRUCTION); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_checks++; if (read_enable !== 1'b0) begin n_errors++; $display("FAIL reset_first_edge_idle: read_enable got %b expected 0", read_enable); end
    tick();
    n_checks++; if (read_enable !== 1'b1) begin n_errors++; $display("FAIL reset_second_edge_fetch: read_enable got %b expected 1", read_enable); end
  endtask

  task automatic test_fetch_exec();
    int n, re_cnt, pc_cnt;
    mode_sel = 1'b0;
    ram_q = 16'h1234;
    exp_q.push_back(16'h1234);
    do_reset();
    tick();
    tick();
    re_cnt = 0;
    n = 0;
    while (!instr_valid && n < 30) begin
      if (read_enable) re_cnt++;
      tick();
      n++;
    end
    n_checks++; if (n != 3) begin n_errors++; $display("FAIL s1_latency: got %0d edges expected 3", n); end
    n_checks++; if (re_cnt != 2) begin n_errors++; $display("FAIL s1_read_enable_cycles: got %0d expected 2", re_cnt); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s1_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s1_instr: got %h expected %h", INSTRUCTION, exp); end end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (instr_valid !== 1'b1 || INSTRUCTION !== 16'h1234) begin n_errors++; $display("FAIL s1_hold: valid=%b instr=%h expected 1/1234", instr_valid, INSTRUCTION); end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    pc_cnt = pc_advance ? 1 : 0;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL s1_valid_after_done: got %b expected 0", instr_valid); end
    ram_q = 16'h4321;
    exp_q.push_back(16'h4321);
    tick();
    if (pc_advance) pc_cnt++;
    n_checks++; if (pc_cnt != 1) begin n_errors++; $display("FAIL s1_pc_pulses: got %0d expected 1", pc_cnt); end
    n_checks++; if (read_enable !== 1'b1) begin n_errors++; $display("FAIL s1_refetch: read_enable got %b expected 1", read_enable); end
    wait_valid(n);
    n_checks++; if (n != 3) begin n_errors++; $display("FAIL b2b_latency: got %0d edges expected 3", n); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL b2b_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL b2b_instr: got %h expected %h", INSTRUCTION, exp); end end
  endtask

  task automatic test_cc_wren();
    int n;
    mode_sel = 1'b0;
    ram_q = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    do_reset();
    tick();
    tick();
    tick();
    cc_wren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (read_enable !== 1'b0) begin n_errors++; $display("FAIL s2_re_blocked[%0d]: got %b expected 0", i, read_enable); end
      tick();
    end
    cc_wren = 1'b0;
    #1;
    n_checks++; if (read_enable !== 1'b1) begin n_errors++; $display("FAIL s2_restart: read_enable got %b expected 1", read_enable); end
    wait_valid(n);
    n_checks++; if (n != 3) begin n_errors++; $display("FAIL s2_latency: got %0d edges expected 3", n); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s2_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s2_instr: got %h expected %h", INSTRUCTION, exp); end end
    cc_wren = 1'b1;
    #1;
    n_checks++; if (read_enable !== 1'b0 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL s2_wren_in_exec: re=%b valid=%b expected 0/1", read_enable, instr_valid); end
    tick();
    cc_wren = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL s2_exec_unaffected: valid got %b expected 1", instr_valid); end
  endtask

  task automatic test_halt();
    int n, pc_cnt, drop_cnt;
    mode_sel = 1'b0;
    ram_q = 16'h0000;
    exp_q.push_back(16'h0000);
    do_reset();
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL s3_halt_edge: got %0d expected 5", n); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL s3_valid: got %b expected 0", instr_valid); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s3_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s3_instr: got %h expected %h", INSTRUCTION, exp); end end
    pc_cnt = 0;
    drop_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      done = (i % 2 == 0);
      tick();
      if (pc_advance || read_enable) pc_cnt++;
      if (!halted || instr_valid) drop_cnt++;
    end
    done = 1'b0;
    n_checks++; if (pc_cnt != 0) begin n_errors++; $display("FAIL s3_no_advance: got %0d active cycles expected 0", pc_cnt); end
    n_checks++; if (drop_cnt != 0) begin n_errors++; $display("FAIL s3_stays_halted: got %0d bad cycles expected 0", drop_cnt); end
    mode_sel = 1'b1;
    external_INSTRUCTION = 16'h00EE;
    tick();
    n_checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin n_errors++; $display("FAIL s3_leave_halt: halted=%b valid=%b expected 0/0", halted, instr_valid); end
    exp_q.push_back(16'h00EE);
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL s3_ext_entry: valid got %b expected 1", instr_valid); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s3_ext_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s3_ext_instr: got %h expected %h", INSTRUCTION, exp); end end
  endtask

  task automatic test_ext_mode();
    mode_sel = 1'b1;
    external_INSTRUCTION = ext_vals[0];
    exp_q.push_back(ext_vals[0]);
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({instr_valid, read_enable, pc_advance} !== 3'b100) begin n_errors++; $display("FAIL s4_flags[%0d]: got %b expected 100", i, {instr_valid, read_enable, pc_advance}); end
      n_checks++;
      if (exp_q.size() == 0) begin n_errors++; $display("FAIL s4_instr[%0d]: scoreboard empty", i); end
      else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s4_instr[%0d]: got %h expected %h", i, INSTRUCTION, exp); end end
      if (i < 3) begin
        external_INSTRUCTION = ext_vals[i+1];
        exp_q.push_back(ext_vals[i+1]);
        done = 1'b1;
        #1;
        n_checks++; if (INSTRUCTION !== ext_vals[i]) begin n_errors++; $display("FAIL s4_delay[%0d]: got %h expected %h", i, INSTRUCTION, ext_vals[i]); end
        tick();
      end
    end
    done = 1'b0;
  endtask

  task automatic test_reset_exec();
    int n;
    mode_sel = 1'b0;
    ram_q = 16'h5555;
    exp_q.push_back(16'h5555);
    do_reset();
    wait_valid(n);
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL s5_valid_edge: got %0d expected 5", n); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s5_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s5_instr: got %h expected %h", INSTRUCTION, exp); end end
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if ({read_enable, pc_advance, instr_valid, halted} !== 4'b0000) begin n_errors++; $display("FAIL s5_async_flags: got %b expected 0000", {read_enable, pc_advance, instr_valid, halted}); end
    n_checks++; if (INSTRUCTION !== 16'h0000) begin n_errors++; $display("FAIL s5_async_instr: got %h expected 0000", INSTRUCTION); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_checks++; if (instr_valid !== 1'b0 || read_enable !== 1'b0) begin n_errors++; $display("FAIL s5_discarded: valid=%b re=%b expected 0/0", instr_valid, read_enable); end
  endtask

  task automatic test_done_abort();
    int n;
    mode_sel = 1'b0;
    ram_q = 16'h7777;
    exp_q.push_back(16'h7777);
    do_reset();
    wait_valid(n);
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL s6_valid_edge: got %0d expected 5", n); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s6_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s6_instr: got %h expected %h", INSTRUCTION, exp); end end
    external_INSTRUCTION = 16'hC0DE;
    done = 1'b1;
    mode_sel = 1'b1;
    tick();
    done = 1'b0;
    n_checks++; if ({pc_advance, instr_valid, read_enable} !== 3'b000) begin n_errors++; $display("FAIL s6_abort_flags: got %b expected 000", {pc_advance, instr_valid, read_enable}); end
    n_checks++; if (INSTRUCTION !== 16'h7777) begin n_errors++; $display("FAIL s6_instr_kept: got %h expected 7777", INSTRUCTION); end
    exp_q.push_back(16'hC0DE);
    tick();
    n_checks++; if (instr_valid !== 1'b1 || pc_advance !== 1'b0) begin n_errors++; $display("FAIL s6_ext: valid=%b pc=%b expected 1/0", instr_valid, pc_advance); end
    n_checks++;
    if (exp_q.size() == 0) begin n_errors++; $display("FAIL s6_ext_instr: scoreboard empty"); end
    else begin exp = exp_q.pop_front(); if (INSTRUCTION !== exp) begin n_errors++; $display("FAIL s6_ext_instr: got %h expected %h", INSTRUCTION, exp); end end
  endtask

  initial begin
    test_reset();
    test_fetch_exec();
    test_cc_wren();
    test_halt();
    test_ext_mode();
    test_reset_exec();
    test_done_abort();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drained: got %0d entries expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
